// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end. It issues in-order word reads to
// instruction memory under a shared credit limit, pairs each returned word with
// its address from an in-order PC queue, and buffers {word, pc} in a small FIFO
// for the core. A redirect flushes the FIFO and PC queue and drops the
// responses still in flight.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc
);
    // Storage is sized for the largest legal DEPTH (4); pointers wrap at DEPTH.
    localparam int            PW      = 2;
    localparam int            CW      = 3;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

    // Circular pointer increment, wrapping after entry DEPTH-1.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        logic [PW-1:0] n;
        if (p == LAST_C) begin
            n = 2'd0;
        end else begin
            n = p + 2'd1;
        end
        return n;
    endfunction

    logic          run_q, run_d;
    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [31:0]   pcq_q [4];
    logic [31:0]   pcq_d [4];
    logic [PW-1:0] pcq_rd_q, pcq_rd_d, pcq_wr_q, pcq_wr_d;
    logic [CW-1:0] pcq_cnt_q, pcq_cnt_d;
    logic [31:0]   fd_q [4];
    logic [31:0]   fd_d [4];
    logic [31:0]   fp_q [4];
    logic [31:0]   fp_d [4];
    logic [PW-1:0] f_rd_q, f_rd_d, f_wr_q, f_wr_d;
    logic [CW-1:0] f_cnt_q, f_cnt_d;

    logic          deliver_s;
    logic          req_fire_s;
    logic          rsp_keep_s;
    logic [CW-1:0] inflight_s;
    logic [CW-1:0] occ_s;

    // Handshakes and the credit check; a delivery this cycle frees its slot.
    always_comb begin
        inst_valid    = (f_cnt_q != 3'd0);
        deliver_s     = inst_valid & inst_ready;
        inflight_s    = pcq_cnt_q + drop_q;
        occ_s         = inflight_s + f_cnt_q - CW'(deliver_s);
        mem_req_valid = run_q & ~redirect_valid & (occ_s < DEPTH_C);
        mem_req_addr  = pc_q;
        req_fire_s    = mem_req_valid & mem_req_ready;
        rsp_keep_s    = mem_rsp_valid & (drop_q == 3'd0) & ~redirect_valid;
        inst_data     = fd_q[f_rd_q];
        inst_pc       = fp_q[f_rd_q];
    end

    // Next-state: redirect flush, request issue, response capture, delivery.
    always_comb begin
        run_d     = 1'b1;
        pc_d      = pc_q;
        drop_d    = drop_q;
        pcq_d     = pcq_q;
        pcq_rd_d  = pcq_rd_q;
        pcq_wr_d  = pcq_wr_q;
        pcq_cnt_d = pcq_cnt_q;
        fd_d      = fd_q;
        fp_d      = fp_q;
        f_rd_d    = f_rd_q;
        f_wr_d    = f_wr_q;
        f_cnt_d   = f_cnt_q;
        if (redirect_valid) begin
            // Every request still in flight after this cycle must be dropped,
            // including those already counted from an earlier redirect.
            pc_d      = redirect_pc & 32'hFFFF_FFFC;
            drop_d    = inflight_s - CW'(mem_rsp_valid);
            pcq_rd_d  = 2'd0;
            pcq_wr_d  = 2'd0;
            pcq_cnt_d = 3'd0;
            f_rd_d    = 2'd0;
            f_wr_d    = 2'd0;
            f_cnt_d   = 3'd0;
        end else begin
            if (req_fire_s) begin
                pc_d            = pc_q + 32'd4;
                pcq_d[pcq_wr_q] = pc_q;
                pcq_wr_d        = ptr_inc(pcq_wr_q);
            end else begin
                pc_d = pc_q;
            end
            if (rsp_keep_s) begin
                pcq_rd_d     = ptr_inc(pcq_rd_q);
                fd_d[f_wr_q] = mem_rsp_data;
                fp_d[f_wr_q] = pcq_q[pcq_rd_q];
                f_wr_d       = ptr_inc(f_wr_q);
            end else if (mem_rsp_valid) begin
                drop_d = drop_q - 3'd1;
            end else begin
                drop_d = drop_q;
            end
            if (deliver_s) begin
                f_rd_d = ptr_inc(f_rd_q);
            end else begin
                f_rd_d = f_rd_q;
            end
            pcq_cnt_d = pcq_cnt_q + CW'(req_fire_s) - CW'(rsp_keep_s);
            f_cnt_d   = f_cnt_q + CW'(rsp_keep_s) - CW'(deliver_s);
        end
    end

    // State registers with asynchronous reset to the idle, empty state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q     <= 1'b0;
            pc_q      <= RESET_PC;
            drop_q    <= 3'd0;
            pcq_rd_q  <= 2'd0;
            pcq_wr_q  <= 2'd0;
            pcq_cnt_q <= 3'd0;
            f_rd_q    <= 2'd0;
            f_wr_q    <= 2'd0;
            f_cnt_q   <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                pcq_q[i] <= 32'd0;
                fd_q[i]  <= 32'd0;
                fp_q[i]  <= 32'd0;
            end
        end else begin
            run_q     <= run_d;
            pc_q      <= pc_d;
            drop_q    <= drop_d;
            pcq_rd_q  <= pcq_rd_d;
            pcq_wr_q  <= pcq_wr_d;
            pcq_cnt_q <= pcq_cnt_d;
            f_rd_q    <= f_rd_d;
            f_wr_q    <= f_wr_d;
            f_cnt_q   <= f_cnt_d;
            for (int i = 0; i < 4; i++) begin
                pcq_q[i] <= pcq_d[i];
                fd_q[i]  <= fd_d[i];
                fp_q[i]  <= fp_d[i];
            end
        end
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 Parameter DEPTH, default 2, is the combined limit on in-flight requests plus buffered instructions; legal range is 1..4.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 Port redirect_valid, input, 1 bit: a taken branch or jump from the core.
REQ-006 Port redirect_pc, input, 32 bits: the new fetch address, sampled when redirect_valid=1.
REQ-007 Port mem_req_valid, output, 1 bit: an instruction-memory read request.
REQ-008 Port mem_req_ready, input, 1 bit: the memory accepts the request.
REQ-009 Port mem_req_addr, output, 32 bits: the word address of the request.
REQ-010 Port mem_rsp_valid, input, 1 bit: read data is returned, in order, at least 1 cycle after acceptance.
REQ-011 Port mem_rsp_data, input, 32 bits: the returned instruction word.
REQ-012 Port inst_valid, output, 1 bit: an instruction is offered to the core.
REQ-013 Port inst_ready, input, 1 bit: the core consumes the offered instruction.
REQ-014 Port inst_data, output, 32 bits: the offered instruction word.
REQ-015 Port inst_pc, output, 32 bits: the address of the offered instruction.

Function
REQ-016 A request handshake occurs on a cycle with mem_req_valid=1 and mem_req_ready=1.
REQ-017 A delivery handshake occurs on a cycle with inst_valid=1 and inst_ready=1.
REQ-018 mem_req_valid is 1 only when outstanding + buffered < DEPTH and redirect_valid=0 in the same cycle.
REQ-019 Once mem_req_valid is asserted, it and mem_req_addr stay stable until accepted or a redirect occurs.
REQ-020 Each accepted request advances the fetch PC by 4, wrapping modulo 2^32, and pushes its address into an in-order PC queue of DEPTH entries.
REQ-021 Each valid response pops the PC queue and writes {word, pc} into a DEPTH-entry instruction FIFO, except when the response is being dropped (REQ-025, REQ-026).
REQ-022 inst_valid is the FIFO not-empty flag; inst_data and inst_pc show the FIFO head.
REQ-023 A response written into an empty FIFO is visible at the outputs on the next cycle; there is no same-cycle bypass.
REQ-024 A response and a delivery in the same cycle are both honoured; the credit rule in REQ-018 guarantees the FIFO never overflows.
REQ-025 redirect_valid=1 applies on the next edge:
  - the FIFO is emptied;
  - the fetch PC is loaded with {redirect_pc[31:2], 2'b00};
  - the drop counter is loaded with the number of in-flight requests;
  - the PC queue is cleared.
REQ-026 While the drop counter is nonzero, each response decrements it and is discarded; this includes a response arriving in the redirect cycle itself.
REQ-027 A delivery handshake in a redirect cycle completes; the following instruction is then flushed.
REQ-028 Back-to-back redirects: the last one wins, and the drop count accumulates correctly.
REQ-029 Steady state with DEPTH=2, zero stalls and memory latency 1 sustains one instruction per cycle.

Reset
REQ-030 While rst_n=0, the block holds:
  - mem_req_valid=0 and inst_valid=0;
  - inst_data=0 and inst_pc=0;
  - fetch PC = mem_req_addr = RESET_PC;
  - FIFO, PC queue, outstanding count and drop counter all zero.
REQ-031 Reset asserted mid-operation discards all state immediately; responses arriving during or after reset, for pre-reset requests, are the memory's responsibility to suppress.
REQ-032 The first request, to RESET_PC, is asserted on the first rising edge after rst_n deasserts.

Verification
REQ-033 Reset release, mem_req_ready=1, latency 1, inst_ready=1 -> inst_pc sequence 0,4,8,12 on consecutive cycles, with inst_data matching memory.
REQ-034 inst_ready=0 for 10 cycles -> exactly DEPTH=2 requests issued and mem_req_valid held low; on release, instructions 0 and 4 are delivered in order with no loss or duplication.
REQ-035 Two requests in flight, then redirect_pc=32'h0000_0103 -> both old responses dropped, next request address is 32'h0000_0100, and the first delivered inst_pc is 32'h0000_0100.
REQ-036 Redirect in the same cycle as a response and a delivery -> the delivered instruction completes, the response is dropped, and the FIFO is empty next cycle.
REQ-037 mem_req_ready=0 for 3 cycles -> mem_req_addr is stable throughout; fetch PC 32'hFFFF_FFFC followed by the next request gives address 32'h0000_0000 (wrap).
REQ-038 rst_n pulsed low mid-stream -> all outputs return to reset values asynchronously, and fetch restarts at RESET_PC.
